// File: rtl/systema_cpu_cpu_debug_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : systema_cpu_cpu_debug_mem_arbiter
// Purpose  : Shares one debug RAM port between a JTAG strobe path and an
//            Avalon-MM slave (round-robin or JTAG-priority arbitration).
// Revision : 1.0 - initial release
// ============================================================================
module systema_cpu_cpu_debug_mem_arbiter #(
    parameter int ADDR_W    = 8,
    parameter int JTAG_PRIO = 0
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic              jtag_req,
    input  logic              jtag_write,
    input  logic [ADDR_W-1:0] jtag_addr,
    input  logic [31:0]       jtag_wdata,
    output logic [31:0]       jtag_rdata,
    output logic              jtag_done,
    output logic              jtag_overrun,

    input  logic              av_read,
    input  logic              av_write,
    input  logic [ADDR_W-1:0] av_address,
    input  logic [31:0]       av_writedata,
    output logic [31:0]       av_readdata,
    output logic              av_waitrequest,

    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [31:0]       mem_rdata,

    output logic              busy
);

    localparam logic c_JTAG_WINS = (JTAG_PRIO != 0);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACCESS  = 2'd1,
        S_CAPTURE = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_slot_valid;
    logic                r_slot_write;
    logic [ADDR_W-1:0]   r_slot_addr;
    logic [31:0]         r_slot_wdata;
    logic                r_owner_jtag;
    logic                r_op_write;
    logic                r_last_jtag;

    logic                w_jtag_inflight;
    logic                w_jtag_accept;
    logic                w_jtag_pend;
    logic                w_jtag_wr;
    logic [ADDR_W-1:0]   w_jtag_addr;
    logic [31:0]         w_jtag_wdata;
    logic                w_av_req;
    logic                w_grant;
    logic                w_grant_jtag;
    logic                w_complete;

    // A fresh strobe bypasses the slot so an idle arbiter can grant it at once.
    assign w_jtag_inflight = (r_state != S_IDLE) && r_owner_jtag;
    assign w_jtag_accept   = jtag_req && !r_slot_valid && !w_jtag_inflight;
    assign w_jtag_pend     = r_slot_valid || w_jtag_accept;
    assign w_jtag_wr       = r_slot_valid ? r_slot_write : jtag_write;
    assign w_jtag_addr     = r_slot_valid ? r_slot_addr  : jtag_addr;
    assign w_jtag_wdata    = r_slot_valid ? r_slot_wdata : jtag_wdata;

    assign w_av_req        = av_read || av_write;
    assign w_grant         = (r_state == S_IDLE) && (w_av_req || w_jtag_pend);
    assign w_grant_jtag    = w_jtag_pend && (!w_av_req || c_JTAG_WINS || !r_last_jtag);

    assign w_complete      = ((r_state == S_ACCESS) && r_op_write) || (r_state == S_CAPTURE);

    assign av_waitrequest  = !(w_complete && !r_owner_jtag);
    assign av_readdata     = ((r_state == S_CAPTURE) && !r_owner_jtag) ? mem_rdata : 32'd0;
    assign busy            = (r_state != S_IDLE) || r_slot_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_slot_valid <= 1'b0;
            r_slot_write <= 1'b0;
            r_slot_addr  <= '0;
            r_slot_wdata <= 32'd0;
            r_owner_jtag <= 1'b0;
            r_op_write   <= 1'b0;
            r_last_jtag  <= 1'b0;
            jtag_rdata   <= 32'd0;
            jtag_done    <= 1'b0;
            jtag_overrun <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= 32'd0;
            mem_we       <= 1'b0;
            mem_re       <= 1'b0;
        end else begin
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
            jtag_done <= w_complete && r_owner_jtag;

            if ((r_state == S_CAPTURE) && r_owner_jtag) begin
                jtag_rdata <= mem_rdata;
            end

            if (jtag_req && !w_jtag_accept) begin
                jtag_overrun <= 1'b1;
            end

            if (w_grant && w_grant_jtag) begin
                r_slot_valid <= 1'b0;
            end else if (w_jtag_accept) begin
                r_slot_valid <= 1'b1;
                r_slot_write <= jtag_write;
                r_slot_addr  <= jtag_addr;
                r_slot_wdata <= jtag_wdata;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_state      <= S_ACCESS;
                        r_owner_jtag <= w_grant_jtag;
                        r_last_jtag  <= w_grant_jtag;
                        if (w_grant_jtag) begin
                            r_op_write <= w_jtag_wr;
                            mem_addr   <= w_jtag_addr;
                            mem_wdata  <= w_jtag_wdata;
                            mem_we     <= w_jtag_wr;
                            mem_re     <= !w_jtag_wr;
                        end else begin
                            // Simultaneous read and write is resolved as a write.
                            r_op_write <= av_write;
                            mem_addr   <= av_address;
                            mem_wdata  <= av_writedata;
                            mem_we     <= av_write;
                            mem_re     <= !av_write;
                        end
                    end
                end
                S_ACCESS: begin
                    r_state <= r_op_write ? S_IDLE : S_CAPTURE;
                end
                S_CAPTURE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/systema_cpu_cpu_debug_mem_arbiter.md
SYSTEMA_CPU_CPU_DEBUG_MEM_ARBITER -- requirements
Module: systema_cpu_cpu_debug_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 8: debug memory word-address width.
REQ-002 SHALL have parameter JTAG_PRIO, default 0: 0 = round-robin, 1 = JTAG always wins ties.
REQ-003 SHALL have port clk  in  1: single clock for all logic.
REQ-004 SHALL have port reset_n  in  1: reset, asynchronous and active-low.
REQ-005 SHALL have port jtag_req  in  1: one-cycle request strobe from the sysclk-side debug slave decode.
REQ-006 SHALL have port jtag_write  in  1: 1 = write, 0 = read; sampled with jtag_req.
REQ-007 SHALL have port jtag_addr  in  ADDR_W: JTAG word address, sampled with jtag_req.
REQ-008 SHALL have port jtag_wdata  in  32: JTAG write data, sampled with jtag_req.
REQ-009 SHALL have port jtag_rdata  out  32: last JTAG read result; holds until the next JTAG read completes.
REQ-010 SHALL have port jtag_done  out  1: one-cycle completion pulse for a JTAG transfer.
REQ-011 SHALL have port jtag_overrun  out  1: sticky flag; a jtag_req arrived while a JTAG request was pending or in flight.
REQ-012 SHALL have port av_read  in  1: Avalon-MM read, held until accepted.
REQ-013 SHALL have port av_write  in  1: Avalon-MM write, held until accepted.
REQ-014 SHALL have port av_address  in  ADDR_W: Avalon word address.
REQ-015 SHALL have port av_writedata  in  32: Avalon write data.
REQ-016 SHALL have port av_readdata  out  32: Avalon read data, valid when av_read=1 and av_waitrequest=0.
REQ-017 SHALL have port av_waitrequest  out  1: Avalon stall.
REQ-018 SHALL have port mem_addr  out  ADDR_W: debug RAM address.
REQ-019 SHALL have port mem_wdata  out  32: debug RAM write data.
REQ-020 SHALL have port mem_we  out  1: debug RAM write enable, one cycle per write.
REQ-021 SHALL have port mem_re  out  1: debug RAM read enable; mem_rdata is valid on the following cycle.
REQ-022 SHALL have port mem_rdata  in  32: debug RAM read data.
REQ-023 SHALL have port busy  out  1: FSM state is not IDLE, or a JTAG request is pending.

Function
REQ-024 SHALL latch jtag_req, jtag_write, jtag_addr and jtag_wdata into a pending slot; the slot clears when the request is granted.
REQ-025 SHALL set jtag_overrun and discard the new strobe when jtag_req=1 while the slot is full or a JTAG transfer is in flight.
REQ-026 SHALL implement FSM states IDLE, ACCESS and CAPTURE.
REQ-027 In IDLE with at least one request, SHALL grant, register addr/data/op/owner, update last_grant, and move to ACCESS next cycle.
REQ-028 Arbitration SHALL grant the sole requester; on a tie: JTAG_PRIO=1 grants JTAG; JTAG_PRIO=0 grants the requester not equal to last_grant.
REQ-029 ACCESS SHALL drive mem_addr/mem_wdata from the registered values, assert mem_we (write) or mem_re (read) for exactly one cycle, then go to IDLE for a write or CAPTURE for a read.
REQ-030 CAPTURE SHALL last one cycle; Avalon owner: av_readdata = mem_rdata; JTAG owner: jtag_rdata <= mem_rdata. Then IDLE.
REQ-031 Completion cycle SHALL be ACCESS for writes and CAPTURE for reads; av_waitrequest SHALL be 0 only in an Avalon-owned completion cycle, 1 otherwise.
REQ-032 jtag_done SHALL pulse on the cycle after a JTAG-owned completion cycle.
REQ-033 Latency SHALL be, from a request seen in IDLE: write completes in 2 cycles, read in 3; back-to-back grants need one IDLE cycle between transfers.
REQ-034 av_read=1 together with av_write=1 SHALL be treated as a write.
REQ-035 Avalon requests dropped before grant SHALL cause no memory access; dropped during ACCESS/CAPTURE, the transfer SHALL still complete.
REQ-036 mem_we and mem_re SHALL never both be 1.

Reset
REQ-037 On reset_n=0, immediately and asynchronously: FSM=IDLE, slot empty, last_grant=Avalon, jtag_rdata=0, jtag_done=0, jtag_overrun=0, mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0, av_readdata=0, av_waitrequest=1, busy=0.
REQ-038 Reset asserted mid-transfer SHALL abort it, with no further mem_we/mem_re and no jtag_done.

Verification
REQ-039 Avalon write addr 0x10, data 0xDEADBEEF -> mem_we high for 1 cycle at cycle 1 with those values; av_waitrequest=0 in that cycle only.
REQ-040 JTAG read addr 0x20 with RAM returning 0x12345678 -> mem_re at cycle 1; jtag_rdata=0x12345678 and jtag_done pulse at cycle 3.
REQ-041 JTAG and Avalon requests in the same IDLE cycle after reset, JTAG_PRIO=0 -> JTAG served first, Avalon next; repeated tie alternates.
REQ-042 Second jtag_req during an in-flight JTAG read -> jtag_overrun=1, exactly one jtag_done, sticky until reset.
REQ-043 reset_n pulsed low during ACCESS of an Avalon read -> all outputs at reset values; no CAPTURE and no mem_re afterwards.
REQ-044 av_read=av_write=1 at addr 0x05 -> write performed; mem_re never asserted.
